// File: rtl/keypad_entry_if.sv
// Keypad entry signal bundle: scan controls and row lines in, column drive and entry results out.
interface keypad_entry_if;
    logic        en;
    logic        clear;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] value;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    modport master (
        output en, clear, row,
        input  col, value, key_code, key_valid, key_held
    );

    modport slave (
        input  en, clear, row,
        output col, value, key_code, key_valid, key_held
    );
endinterface

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner: column scan, debounce of press and release, hex digit entry register.
module keypad_entry #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEBOUNCE_CNT = 100000
) (
    input  logic          clk,
    input  logic          reset,
    keypad_entry_if.slave kp
);
    localparam int unsigned CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t        state_q, state_n;
    logic [1:0]    col_idx_q, col_idx_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [3:0]    cap_row_q, cap_row_n;
    logic [3:0]    row_s1, row_s2;
    logic [3:0]    col_n;
    logic          held_n;
    logic          accept;
    logic [3:0]    key_now;

    // True when exactly one row line is pulled low.
    function automatic logic single_low(input logic [3:0] p);
        logic [3:0] inv;
        inv = ~p;
        return (inv != 4'd0) && ((inv & (inv - 4'd1)) == 4'd0);
    endfunction

    // Row index of a single-low pattern.
    function automatic logic [1:0] low_index(input logic [3:0] p);
        case (p)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // Row-major keypad legend.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'd0:    return 4'h1;
            4'd1:    return 4'h2;
            4'd2:    return 4'h3;
            4'd3:    return 4'hA;
            4'd4:    return 4'h4;
            4'd5:    return 4'h5;
            4'd6:    return 4'h6;
            4'd7:    return 4'hB;
            4'd8:    return 4'h7;
            4'd9:    return 4'h8;
            4'd10:   return 4'h9;
            4'd11:   return 4'hC;
            4'd12:   return 4'h0;
            4'd13:   return 4'hF;
            4'd14:   return 4'hE;
            default: return 4'hD;
        endcase
    endfunction

    assign key_now = key_map(low_index(cap_row_q), col_idx_q);

    // Next-state, counter and column selection.
    always_comb begin
        state_n   = state_q;
        col_idx_n = col_idx_q;
        cnt_n     = cnt_q;
        cap_row_n = cap_row_q;
        held_n    = kp.key_held;
        accept    = 1'b0;

        if (!kp.en) begin
            state_n   = SCAN;
            col_idx_n = 2'd0;
            cnt_n     = '0;
            held_n    = 1'b0;
        end else begin
            case (state_q)
                SCAN: begin
                    if (kp.col == 4'hF) begin
                        // Resuming from pause: the dwell starts once the column is driven.
                        cnt_n = '0;
                    end else if (cnt_q == SCAN_LAST) begin
                        cnt_n = '0;
                        if (single_low(row_s2)) begin
                            cap_row_n = row_s2;
                            state_n   = DEBOUNCE;
                        end else begin
                            col_idx_n = col_idx_q + 2'd1;
                        end
                    end else begin
                        cnt_n = cnt_q + CW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (row_s2 != cap_row_q) begin
                        cnt_n     = '0;
                        col_idx_n = col_idx_q + 2'd1;
                        state_n   = SCAN;
                    end else if (cnt_q == DEB_LAST) begin
                        cnt_n   = '0;
                        accept  = 1'b1;
                        held_n  = 1'b1;
                        state_n = HELD;
                    end else begin
                        cnt_n = cnt_q + CW'(1);
                    end
                end
                HELD: begin
                    cnt_n = '0;
                    if (row_s2 == 4'hF) begin
                        state_n = RELEASE;
                    end
                end
                RELEASE: begin
                    if (row_s2 != 4'hF) begin
                        cnt_n   = '0;
                        state_n = HELD;
                    end else if (cnt_q == DEB_LAST) begin
                        cnt_n     = '0;
                        held_n    = 1'b0;
                        col_idx_n = col_idx_q + 2'd1;
                        state_n   = SCAN;
                    end else begin
                        cnt_n = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_n = SCAN;
                    cnt_n   = '0;
                end
            endcase
        end

        col_n = kp.en ? ~(4'b0001 << col_idx_n) : 4'hF;
    end

    // State, synchronizer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SCAN;
            col_idx_q    <= 2'd0;
            cnt_q        <= '0;
            cap_row_q    <= 4'hF;
            row_s1       <= 4'hF;
            row_s2       <= 4'hF;
            kp.col       <= 4'b1110;
            kp.value     <= 16'h0000;
            kp.key_code  <= 4'h0;
            kp.key_valid <= 1'b0;
            kp.key_held  <= 1'b0;
        end else begin
            row_s1       <= kp.row;
            row_s2       <= row_s1;
            state_q      <= state_n;
            col_idx_q    <= col_idx_n;
            cnt_q        <= cnt_n;
            cap_row_q    <= cap_row_n;
            kp.col       <= col_n;
            kp.key_valid <= accept;
            kp.key_held  <= held_n;
            if (accept) begin
                kp.key_code <= key_now;
            end
            if (kp.clear) begin
                kp.value <= 16'h0000;
            end else if (accept) begin
                kp.value <= {kp.value[11:0], key_now};
            end
        end
    end
endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with a small keypad model driving the row lines.
module tb_keypad_entry;
    localparam int unsigned SCAN_DIV     = 4;
    localparam int unsigned DEBOUNCE_CNT = 3;

    logic clk = 1'b0;
    logic reset;

    keypad_entry_if kif();

    keypad_entry #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kif)
    );

    initial forever #5 clk = ~clk;

    // Keypad model: the pressed pattern appears on the rows only while its column is driven.
    logic       key_down;
    logic [3:0] key_row_pat;
    logic [3:0] key_col_pat;
    assign kif.row = (key_down && (kif.col == key_col_pat)) ? key_row_pat : 4'hF;

    int pulse_cnt = 0;
    always @(negedge clk) begin
        if (kif.key_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        clr_first;
        logic [3:0]  row_pat;
        logic [3:0]  col_pat;
        logic [3:0]  code;
        logic [15:0] val;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_col(input logic [3:0] pat, input bit eq, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if ((kif.col == pat) == eq) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(name, 16'(ok), 16'd1);
    endtask

    task automatic wait_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (kif.key_valid === 1'b1) seen = 1'b1;
        end
        check(name, 16'(seen), 16'd1);
    endtask

    task automatic wait_released(input string name);
        bit gone;
        gone = 1'b0;
        for (int i = 0; i < 100 && !gone; i++) begin
            @(negedge clk);
            if (kif.key_held === 1'b0) gone = 1'b1;
        end
        check(name, 16'(gone), 16'd1);
    endtask

    task automatic press_key(input logic [3:0] rp, input logic [3:0] cp,
                             input logic [3:0] code, input logic [15:0] val);
        int start;
        start       = pulse_cnt;
        key_row_pat = rp;
        key_col_pat = cp;
        key_down    = 1'b1;
        wait_valid("key_valid seen");
        check("key_code", 16'(kif.key_code), 16'(code));
        check("value", kif.value, val);
        check("key_held on accept", 16'(kif.key_held), 16'd1);
        repeat (20) @(negedge clk);
        check("key_held while down", 16'(kif.key_held), 16'd1);
        key_down = 1'b0;
        wait_released("key_held drop");
        repeat (3) @(negedge clk);
        check("single key_valid", 16'(pulse_cnt - start), 16'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;

        vecs[0] = '{1'b0, 4'b1101, 4'b1011, 4'h6, 16'h0006};
        vecs[1] = '{1'b1, 4'b1110, 4'b1110, 4'h1, 16'h0001};
        vecs[2] = '{1'b0, 4'b1110, 4'b0111, 4'hA, 16'h001A};
        vecs[3] = '{1'b0, 4'b0111, 4'b1110, 4'h0, 16'h01A0};
        vecs[4] = '{1'b0, 4'b0111, 4'b0111, 4'hD, 16'h1A0D};
        vecs[5] = '{1'b0, 4'b1101, 4'b1101, 4'h5, 16'hA0D5};
        vecs[6] = '{1'b1, 4'b1110, 4'b1110, 4'h1, 16'h0001};
        vecs[7] = '{1'b0, 4'b1110, 4'b1101, 4'h2, 16'h0012};
        vecs[8] = '{1'b0, 4'b1110, 4'b1011, 4'h3, 16'h0123};
        vecs[9] = '{1'b0, 4'b1101, 4'b1110, 4'h4, 16'h1234};

        reset       = 1'b1;
        kif.en      = 1'b1;
        kif.clear   = 1'b0;
        key_down    = 1'b0;
        key_row_pat = 4'hF;
        key_col_pat = 4'hF;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("reset col", 16'(kif.col), 16'h000E);
        check("reset value", kif.value, 16'h0000);
        check("reset key_code", 16'(kif.key_code), 16'h0000);
        check("reset key_valid", 16'(kif.key_valid), 16'h0000);
        check("reset key_held", 16'(kif.key_held), 16'h0000);

        // Table of single key presses.
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].clr_first) begin
                kif.clear = 1'b1;
                @(negedge clk);
                kif.clear = 1'b0;
                check("clear", kif.value, 16'h0000);
            end
            press_key(vecs[i].row_pat, vecs[i].col_pat, vecs[i].code, vecs[i].val);
        end

        // Clear coincident with acceptance of key 9.
        key_row_pat = 4'b1011;
        key_col_pat = 4'b1011;
        wait_col(4'b1011, 1'b0, "col leaves c2");
        key_down = 1'b1;
        wait_col(4'b1011, 1'b1, "col reaches c2");
        start = pulse_cnt;
        repeat (6) @(negedge clk);
        kif.clear = 1'b1;
        @(negedge clk);
        kif.clear = 1'b0;
        check("clr+accept key_valid", 16'(kif.key_valid), 16'd1);
        check("clr+accept value", kif.value, 16'h0000);
        check("clr+accept key_code", 16'(kif.key_code), 16'h0009);
        @(negedge clk);
        check("clr+accept valid drop", 16'(kif.key_valid), 16'd0);
        key_down = 1'b0;
        wait_released("clr+accept release");
        repeat (3) @(negedge clk);
        check("clr+accept single pulse", 16'(pulse_cnt - start), 16'd1);

        // Bounce: row low for only two debounce cycles.
        wait_col(4'b1011, 1'b0, "bounce col leaves c2");
        key_down = 1'b1;
        wait_col(4'b1011, 1'b1, "bounce col reaches c2");
        start = pulse_cnt;
        repeat (4) @(negedge clk);
        key_down = 1'b0;
        repeat (2) @(negedge clk);
        check("bounce col held", 16'(kif.col), 16'h000B);
        @(negedge clk);
        check("bounce next col", 16'(kif.col), 16'h0007);
        repeat (3) @(negedge clk);
        check("bounce no key_valid", 16'(pulse_cnt - start), 16'd0);
        check("bounce value", kif.value, 16'h0000);

        // Two rows low on column 0: ignored, rotation continues.
        key_row_pat = 4'b1010;
        key_col_pat = 4'b1110;
        wait_col(4'b1110, 1'b0, "multi col leaves c0");
        key_down = 1'b1;
        wait_col(4'b1110, 1'b1, "multi col reaches c0");
        start = pulse_cnt;
        repeat (3) @(negedge clk);
        check("multi dwell c0", 16'(kif.col), 16'h000E);
        @(negedge clk);
        check("multi col c1", 16'(kif.col), 16'h000D);
        repeat (4) @(negedge clk);
        check("multi col c2", 16'(kif.col), 16'h000B);
        repeat (4) @(negedge clk);
        check("multi col c3", 16'(kif.col), 16'h0007);
        repeat (4) @(negedge clk);
        check("multi col wrap", 16'(kif.col), 16'h000E);
        key_down = 1'b0;
        check("multi no key_valid", 16'(pulse_cnt - start), 16'd0);

        // Reset while a key is held; the key is rescanned and accepted once.
        key_row_pat = 4'b1101;
        key_col_pat = 4'b1101;
        key_down    = 1'b1;
        wait_valid("pre-reset key_valid");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = pulse_cnt;
        check("held reset col", 16'(kif.col), 16'h000E);
        check("held reset key_held", 16'(kif.key_held), 16'd0);
        check("held reset key_valid", 16'(kif.key_valid), 16'd0);
        check("held reset value", kif.value, 16'h0000);
        check("held reset key_code", 16'(kif.key_code), 16'h0000);
        wait_valid("rescan key_valid");
        check("rescan key_code", 16'(kif.key_code), 16'h0005);
        check("rescan value", kif.value, 16'h0005);
        repeat (10) @(negedge clk);
        key_down = 1'b0;
        wait_released("rescan release");
        repeat (3) @(negedge clk);
        check("rescan single pulse", 16'(pulse_cnt - start), 16'd1);

        // Scan pause while a key is held, clear during the pause, resume at column 0.
        key_row_pat = 4'b1110;
        key_col_pat = 4'b1011;
        key_down    = 1'b1;
        wait_valid("pause key_valid");
        check("pause key_code", 16'(kif.key_code), 16'h0003);
        check("pause value", kif.value, 16'h0053);
        @(negedge clk);
        kif.en = 1'b0;
        @(negedge clk);
        check("pause col", 16'(kif.col), 16'h000F);
        check("pause key_held", 16'(kif.key_held), 16'd0);
        check("pause key_valid", 16'(kif.key_valid), 16'd0);
        check("pause value hold", kif.value, 16'h0053);
        key_down = 1'b0;
        repeat (2) @(negedge clk);
        kif.clear = 1'b1;
        @(negedge clk);
        kif.clear = 1'b0;
        check("pause clear", kif.value, 16'h0000);
        check("pause key_code hold", 16'(kif.key_code), 16'h0003);
        check("pause col still off", 16'(kif.col), 16'h000F);
        @(negedge clk);
        kif.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("resume dwell c0", 16'(kif.col), 16'h000E);
        end
        @(negedge clk);
        check("resume next col", 16'(kif.col), 16'h000D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
